// File: rtl/alu_core.sv
// alu_core: execute-stage ALU with operand forwarding and C/Z/N flag register.
// Ports: clk, rst_n (async active-low); register_content1/2, alu_control_signal,
//   instruction (imm, [3:0]=shift); wb1/mem_write1/mem_read/reg2_buf2/result_buf
//   (EX/MEM); wb2/mem_write2/reg2_buf3/result_buf2/mem_read_load_case/
//   memory_data_output_load_case (MEM/WB); reg1_buf1/reg2_buf1 (operand addrs).
//   Outputs: out, carry, zero, neg (next flags), in_dst (op2), forward_unit_src (op1).
// Build option: define ALU_LOAD_FWD_EN to forward MEM/WB load data.
module alu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] register_content1,
    input  logic [15:0] register_content2,
    input  logic [3:0]  alu_control_signal,
    input  logic [15:0] instruction,
    input  logic        wb1,
    input  logic        mem_write1,
    input  logic        wb2,
    input  logic        mem_write2,
    input  logic [15:0] result_buf,
    input  logic [15:0] result_buf2,
    input  logic [2:0]  reg1_buf1,
    input  logic [2:0]  reg2_buf1,
    input  logic [2:0]  reg2_buf2,
    input  logic [2:0]  reg2_buf3,
    input  logic        mem_read,
    input  logic        mem_read_load_case,
    input  logic [15:0] memory_data_output_load_case,
    output logic [15:0] out,
    output logic        carry,
    output logic        zero,
    output logic        neg,
    output logic [15:0] in_dst,
    output logic [15:0] forward_unit_src
);

    logic        r_c;
    logic        r_z;
    logic        r_n;

    logic [15:0] w_op1;
    logic [15:0] w_op2;
    logic [15:0] w_mw_data;
    logic        w_ex_hit1;
    logic        w_ex_hit2;
    logic        w_mw_hit1;
    logic        w_mw_hit2;

    logic [3:0]  w_sh;
    logic [16:0] w_add;
    logic [16:0] w_sub;
    logic [16:0] w_inc;
    logic [16:0] w_dec;
    logic [16:0] w_iadd;
    logic [16:0] w_shl17;
    logic [16:0] w_shr17;

    logic [15:0] w_out;
    logic        w_c;
    logic        w_z;
    logic        w_n;
    logic        w_upd_zn;

    // MEM/WB forwarded value; load data only when load forwarding is built in.
`ifdef ALU_LOAD_FWD_EN
    assign w_mw_data = mem_read_load_case ? memory_data_output_load_case
                                          : result_buf2;
`else
    logic w_unused_ld;
    assign w_unused_ld = ^{mem_read_load_case, memory_data_output_load_case};
    assign w_mw_data   = result_buf2;
`endif

    // A load sitting in EX/MEM has no data yet, so it never forwards.
    assign w_ex_hit1 = wb1 && !mem_write1 && !mem_read && (reg2_buf2 == reg1_buf1);
    assign w_ex_hit2 = wb1 && !mem_write1 && !mem_read && (reg2_buf2 == reg2_buf1);
    assign w_mw_hit1 = wb2 && !mem_write2 && (reg2_buf3 == reg1_buf1);
    assign w_mw_hit2 = wb2 && !mem_write2 && (reg2_buf3 == reg2_buf1);

    assign w_op1 = w_ex_hit1 ? result_buf :
                   w_mw_hit1 ? w_mw_data  : register_content1;
    assign w_op2 = w_ex_hit2 ? result_buf :
                   w_mw_hit2 ? w_mw_data  : register_content2;

    assign forward_unit_src = w_op1;
    assign in_dst           = w_op2;

    assign w_sh   = instruction[3:0];
    assign w_add  = {1'b0, w_op2} + {1'b0, w_op1};
    assign w_sub  = {1'b0, w_op2} - {1'b0, w_op1};
    assign w_inc  = {1'b0, w_op2} + 17'd1;
    assign w_dec  = {1'b0, w_op2} - 17'd1;
    assign w_iadd = {1'b0, w_op1} + {1'b0, instruction};
    // Widened shifts: the bit shifted out lands in bit 16 / bit 0.
    assign w_shl17 = {1'b0, w_op1} << w_sh;
    assign w_shr17 = {w_op1, 1'b0} >> w_sh;

    always_comb begin
        w_out    = w_op2;
        w_c      = r_c;
        w_upd_zn = 1'b0;
        unique case (alu_control_signal)
            4'd0:  w_out = w_op2;
            4'd1:  w_c   = 1'b1;
            4'd2:  w_c   = 1'b0;
            4'd3: begin
                w_out    = ~w_op2;
                w_upd_zn = 1'b1;
            end
            4'd4: begin
                w_out    = w_inc[15:0];
                w_c      = w_inc[16];
                w_upd_zn = 1'b1;
            end
            4'd5: begin
                w_out    = w_dec[15:0];
                w_c      = w_dec[16];
                w_upd_zn = 1'b1;
            end
            4'd6:  w_out = w_op1;
            4'd7: begin
                w_out    = w_add[15:0];
                w_c      = w_add[16];
                w_upd_zn = 1'b1;
            end
            4'd8: begin
                w_out    = w_sub[15:0];
                w_c      = w_sub[16];
                w_upd_zn = 1'b1;
            end
            4'd9: begin
                w_out    = w_op2 & w_op1;
                w_upd_zn = 1'b1;
            end
            4'd10: begin
                w_out    = w_op2 | w_op1;
                w_upd_zn = 1'b1;
            end
            4'd11: begin
                w_out    = w_shl17[15:0];
                w_upd_zn = 1'b1;
                if (w_sh != 4'd0) w_c = w_shl17[16];
            end
            4'd12: begin
                w_out    = w_shr17[16:1];
                w_upd_zn = 1'b1;
                if (w_sh != 4'd0) w_c = w_shr17[0];
            end
            4'd13: begin
                w_out    = w_iadd[15:0];
                w_c      = w_iadd[16];
                w_upd_zn = 1'b1;
            end
            4'd14: w_out = instruction;
            4'd15: w_out = w_op1;
            default: w_out = w_op2;
        endcase
    end

    assign w_z = w_upd_zn ? (w_out == 16'd0) : r_z;
    assign w_n = w_upd_zn ? w_out[15]        : r_n;

    assign out   = w_out;
    assign carry = w_c;
    assign zero  = w_z;
    assign neg   = w_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_c <= w_c;
            r_z <= w_z;
            r_n <= w_n;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against a
// behavioural model of forwarding, operations and the flag register.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] register_content1;
    logic [15:0] register_content2;
    logic [3:0]  alu_control_signal;
    logic [15:0] instruction;
    logic        wb1;
    logic        mem_write1;
    logic        wb2;
    logic        mem_write2;
    logic [15:0] result_buf;
    logic [15:0] result_buf2;
    logic [2:0]  reg1_buf1;
    logic [2:0]  reg2_buf1;
    logic [2:0]  reg2_buf2;
    logic [2:0]  reg2_buf3;
    logic        mem_read;
    logic        mem_read_load_case;
    logic [15:0] memory_data_output_load_case;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic        neg;
    logic [15:0] in_dst;
    logic [15:0] forward_unit_src;

    int checks = 0;
    int errors = 0;

    // model flag register
    logic m_c = 1'b0;
    logic m_z = 1'b0;
    logic m_n = 1'b0;

    alu_core dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .register_content1            (register_content1),
        .register_content2            (register_content2),
        .alu_control_signal           (alu_control_signal),
        .instruction                  (instruction),
        .wb1                          (wb1),
        .mem_write1                   (mem_write1),
        .wb2                          (wb2),
        .mem_write2                   (mem_write2),
        .result_buf                   (result_buf),
        .result_buf2                  (result_buf2),
        .reg1_buf1                    (reg1_buf1),
        .reg2_buf1                    (reg2_buf1),
        .reg2_buf2                    (reg2_buf2),
        .reg2_buf3                    (reg2_buf3),
        .mem_read                     (mem_read),
        .mem_read_load_case           (mem_read_load_case),
        .memory_data_output_load_case (memory_data_output_load_case),
        .out                          (out),
        .carry                        (carry),
        .zero                         (zero),
        .neg                          (neg),
        .in_dst                       (in_dst),
        .forward_unit_src             (forward_unit_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_fwd(input logic [2:0] a,
                                              input logic [15:0] rc);
        if (wb1 && !mem_write1 && !mem_read && reg2_buf2 == a)
            return result_buf;
        if (wb2 && !mem_write2 && reg2_buf3 == a) begin
`ifdef ALU_LOAD_FWD_EN
            if (mem_read_load_case) return memory_data_output_load_case;
`endif
            return result_buf2;
        end
        return rc;
    endfunction

    task automatic model_eval(output logic [15:0] e_out,
                              output logic [15:0] e_src,
                              output logic [15:0] e_dst,
                              output logic e_c, output logic e_z,
                              output logic e_n);
        int unsigned a, b, imm, sh, t;
        bit zn;
        e_src = model_fwd(reg1_buf1, register_content1);
        e_dst = model_fwd(reg2_buf1, register_content2);
        a   = e_src;
        b   = e_dst;
        imm = instruction;
        sh  = instruction[3:0];
        e_c = m_c;
        e_z = m_z;
        e_n = m_n;
        zn  = 1'b1;
        t   = b;
        case (alu_control_signal)
            0:  begin t = b; zn = 0; end
            1:  begin t = b; zn = 0; e_c = 1; end
            2:  begin t = b; zn = 0; e_c = 0; end
            3:  t = ~b;
            4:  begin t = b + 1; e_c = (t > 65535); end
            5:  begin t = b - 1; e_c = (b == 0); end
            6:  begin t = a; zn = 0; end
            7:  begin t = b + a; e_c = (t > 65535); end
            8:  begin t = b - a; e_c = (b < a); end
            9:  t = b & a;
            10: t = b | a;
            11: begin
                t = a << sh;
                if (sh != 0) e_c = ((a >> (16 - sh)) & 1) != 0;
            end
            12: begin
                t = a >> sh;
                if (sh != 0) e_c = ((a >> (sh - 1)) & 1) != 0;
            end
            13: begin t = a + imm; e_c = (t > 65535); end
            14: begin t = imm; zn = 0; end
            default: begin t = a; zn = 0; end
        endcase
        e_out = t[15:0];
        if (zn) begin
            e_z = (e_out == 16'd0);
            e_n = e_out[15];
        end
    endtask

    // advance one clock; model flags take the next values (or clear in reset)
    task automatic tick();
        logic [15:0] o, s, d;
        logic c, z, n;
        model_eval(o, s, d, c, z, n);
        @(posedge clk);
        if (rst_n) begin
            m_c = c; m_z = z; m_n = n;
        end else begin
            m_c = 0; m_z = 0; m_n = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        register_content1 = 0; register_content2 = 0;
        alu_control_signal = 0; instruction = 0;
        wb1 = 0; mem_write1 = 0; wb2 = 0; mem_write2 = 0;
        result_buf = 0; result_buf2 = 0;
        reg1_buf1 = 0; reg2_buf1 = 0; reg2_buf2 = 0; reg2_buf3 = 0;
        mem_read = 0; mem_read_load_case = 0;
        memory_data_output_load_case = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if ({carry, zero, neg} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000", {carry, zero, neg});
        end
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out got %h exp 0000", out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_c = 0; m_z = 0; m_n = 0;
    endtask

    task automatic test_add();
        clear_inputs();
        reg1_buf1 = 1; reg2_buf1 = 2;
        register_content1 = 16'h0003;
        register_content2 = 16'hFFFE;
        alu_control_signal = 4'd7;
        #1;
        checks++;
        if ({out, carry, zero, neg} !== {16'h0001, 3'b100}) begin
            errors++;
            $display("FAIL add out/czn got %h/%b exp 0001/100",
                     out, {carry, zero, neg});
        end
        tick();
    endtask

    task automatic test_sub_nop();
        clear_inputs();
        reg1_buf1 = 1; reg2_buf1 = 2;
        register_content1 = 16'd5;
        register_content2 = 16'd5;
        alu_control_signal = 4'd8;
        #1;
        checks++;
        if ({out, carry, zero} !== {16'h0000, 2'b01}) begin
            errors++;
            $display("FAIL sub out/cz got %h/%b exp 0000/01",
                     out, {carry, zero});
        end
        tick();
        alu_control_signal = 4'd0;
        register_content2 = 16'h8000;
        #1;
        checks++;
        if ({carry, zero, neg} !== 3'b010) begin
            errors++;
            $display("FAIL nop_hold got %b exp 010", {carry, zero, neg});
        end
        tick();
    endtask

    task automatic test_double_hazard();
        clear_inputs();
        reg1_buf1 = 2; reg2_buf1 = 5;
        register_content1 = 16'h1111;
        reg2_buf2 = 2; wb1 = 1; result_buf = 16'h00AA;
        reg2_buf3 = 2; wb2 = 1; result_buf2 = 16'h0055;
        alu_control_signal = 4'd6;
        #1;
        checks++;
        if (forward_unit_src !== 16'h00AA) begin
            errors++;
            $display("FAIL dbl_hazard got %h exp 00aa", forward_unit_src);
        end
        mem_read = 1;
        #1;
        checks++;
        if (forward_unit_src !== 16'h0055) begin
            errors++;
            $display("FAIL ld_exmem_skip got %h exp 0055", forward_unit_src);
        end
        tick();
    endtask

    task automatic test_load_fwd();
        logic [15:0] exp_dst;
        clear_inputs();
        reg2_buf1 = 4; reg2_buf3 = 4; wb2 = 1;
        register_content2 = 16'h7777;
        mem_read_load_case = 1;
        memory_data_output_load_case = 16'h1234;
        result_buf2 = 16'h5555;
`ifdef ALU_LOAD_FWD_EN
        exp_dst = 16'h1234;
`else
        exp_dst = 16'h5555;
`endif
        #1;
        checks++;
        if (in_dst !== exp_dst) begin
            errors++;
            $display("FAIL load_fwd got %h exp %h", in_dst, exp_dst);
        end
        tick();
    endtask

    task automatic test_shift_carry();
        clear_inputs();
        register_content1 = 16'h8001;
        instruction = 16'd1;
        alu_control_signal = 4'd11;
        #1;
        checks++;
        if ({out, carry} !== {16'h0002, 1'b1}) begin
            errors++;
            $display("FAIL shl got %h/%b exp 0002/1", out, carry);
        end
        tick();
        alu_control_signal = 4'd2;
        tick();
        alu_control_signal = 4'd1;
        #1;
        checks++;
        if (carry !== 1'b1) begin
            errors++;
            $display("FAIL setc got %b exp 1", carry);
        end
        tick();
        alu_control_signal = 4'd2;
        #1;
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL clrc got %b exp 0", carry);
        end
        tick();
        alu_control_signal = 4'd0;
        #1;
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL clrc_held got %b exp 0", carry);
        end
    endtask

    task automatic test_random();
        logic [15:0] o, s, d;
        logic c, z, n;
        for (int i = 0; i < 400; i++) begin
            register_content1 = 16'($urandom);
            register_content2 = 16'($urandom);
            alu_control_signal = 4'($urandom);
            instruction = 16'($urandom);
            wb1 = 1'($urandom); mem_write1 = 1'($urandom);
            wb2 = 1'($urandom); mem_write2 = 1'($urandom);
            result_buf = 16'($urandom);
            result_buf2 = 16'($urandom);
            reg1_buf1 = 3'($urandom); reg2_buf1 = 3'($urandom);
            reg2_buf2 = 3'($urandom_range(0, 3));
            reg2_buf3 = 3'($urandom_range(0, 3));
            mem_read = 1'($urandom);
            mem_read_load_case = 1'($urandom);
            memory_data_output_load_case = 16'($urandom);
            if (($urandom & 7) == 0) register_content2 = 16'hFFFF;
            if (($urandom & 7) == 0) register_content1 = register_content2;
            #1;
            model_eval(o, s, d, c, z, n);
            checks++;
            if (out !== o) begin
                errors++;
                $display("FAIL rnd_out op=%0d got %h exp %h",
                         alu_control_signal, out, o);
            end
            checks++;
            if ({forward_unit_src, in_dst} !== {s, d}) begin
                errors++;
                $display("FAIL rnd_fwd got %h/%h exp %h/%h",
                         forward_unit_src, in_dst, s, d);
            end
            checks++;
            if ({carry, zero, neg} !== {c, z, n}) begin
                errors++;
                $display("FAIL rnd_flags op=%0d got %b exp %b",
                         alu_control_signal, {carry, zero, neg}, {c, z, n});
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        reg1_buf1 = 1; reg2_buf1 = 2;
        register_content1 = 16'hFFFF;
        register_content2 = 16'hFFFF;
        alu_control_signal = 4'd7;
        tick();
        alu_control_signal = 4'd0;
        #1;
        checks++;
        if ({carry, zero, neg} !== 3'b101) begin
            errors++;
            $display("FAIL pre_reset got %b exp 101", {carry, zero, neg});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({carry, zero, neg} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got %b exp 000", {carry, zero, neg});
        end
        m_c = 0; m_z = 0; m_n = 0;
        #1 rst_n = 1'b1;
        alu_control_signal = 4'd1;
        tick();
        alu_control_signal = 4'd0;
        #1;
        checks++;
        if ({carry, zero, neg} !== 3'b100) begin
            errors++;
            $display("FAIL post_release got %b exp 100", {carry, zero, neg});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_nop();
        test_double_hazard();
        test_load_fwd();
        test_shift_carry();
        @(negedge clk);
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
